// File: rtl/surf_command_transmitter.sv
`default_nettype none
// ============================================================================
// surf_command_transmitter: queues trigger requests and sends each one as a
// 36-bit LSB-first frame on the SURF command line (start, buf, id, stop).
// Option macro: SURF_CMD_TX_AUTOID_EN (frame ID from an internal counter).
// Revision: 1.0
// ============================================================================
module surf_command_transmitter #(
  parameter int BIT_CLOCKS  = 8,
  parameter int GAP_BITS    = 2,
  parameter int QUEUE_DEPTH = 4,
  parameter int QUIET_BITS  = 40
) (
  input  logic        clk33_i,
  input  logic        rst_n_i,
  input  logic        trig_i,
  input  logic [1:0]  buffer_i,
  input  logic [31:0] event_id_i,
  output logic        full_o,
  output logic        overflow_o,
  output logic        busy_o,
  output logic        frame_done_o,
  output logic        cmd_o
);

  localparam int FRAME_BITS = 36;
  localparam int CC_W       = (BIT_CLOCKS > 1) ? $clog2(BIT_CLOCKS) : 1;
  localparam int MAX_BITS   = (QUIET_BITS > FRAME_BITS) ?
                              ((QUIET_BITS > GAP_BITS) ? QUIET_BITS : GAP_BITS) :
                              ((FRAME_BITS > GAP_BITS) ? FRAME_BITS : GAP_BITS);
  localparam int BIT_W      = $clog2(MAX_BITS);
  localparam int PTR_W      = $clog2(QUEUE_DEPTH);
  localparam int CNT_W      = $clog2(QUEUE_DEPTH + 1);

  localparam logic [1:0] S_QUIET = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [1:0]             state, state_n;
  logic [CC_W-1:0]        cc, cc_n;
  logic [BIT_W-1:0]       bit_cnt, bit_n;
  logic [FRAME_BITS-1:0]  sr, sr_n;

  logic [33:0]            mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       count;
  logic [31:0]            wr_id;
  logic [33:0]            head;
  logic                   push, pop, bit_end;

  assign bit_end      = (cc == CC_W'(BIT_CLOCKS - 1));
  assign pop          = (state == S_IDLE) && (count != '0);
  assign full_o       = (count == CNT_W'(QUEUE_DEPTH));
  assign push         = trig_i && (!full_o || pop);
  assign busy_o       = (state != S_IDLE);
  assign frame_done_o = (state == S_SEND) && bit_end &&
                        (bit_cnt == BIT_W'(FRAME_BITS - 1));
  assign head         = mem[rd_ptr];

`ifdef SURF_CMD_TX_AUTOID_EN
  logic [31:0] auto_id;

  always_ff @(posedge clk33_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      auto_id <= '0;
    end else if (push) begin
      auto_id <= auto_id + 32'd1;
    end
  end

  assign wr_id = auto_id;
`else
  assign wr_id = event_id_i;
`endif

  always_ff @(posedge clk33_i) begin
    if (push) begin
      mem[wr_ptr] <= {buffer_i, wr_id};
    end
  end

  // A full queue can still accept when IDLE pops in the same cycle.
  always_ff @(posedge clk33_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
    end else begin
      overflow_o <= trig_i && !push;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    cc_n    = bit_end ? '0 : cc + CC_W'(1);
    bit_n   = bit_cnt;
    sr_n    = sr;
    case (state)
      S_QUIET: begin
        if (bit_end) begin
          if (bit_cnt == BIT_W'(QUIET_BITS - 1)) begin
            state_n = S_IDLE;
            bit_n   = '0;
          end else begin
            bit_n = bit_cnt + BIT_W'(1);
          end
        end
      end
      S_IDLE: begin
        cc_n = '0;
        if (pop) begin
          state_n = S_SEND;
          bit_n   = '0;
          sr_n    = {1'b0, head[31:0], head[33], head[32], 1'b1};
        end
      end
      S_SEND: begin
        if (bit_end) begin
          sr_n = {1'b0, sr[FRAME_BITS-1:1]};
          if (bit_cnt == BIT_W'(FRAME_BITS - 1)) begin
            state_n = S_GAP;
            bit_n   = '0;
          end else begin
            bit_n = bit_cnt + BIT_W'(1);
          end
        end
      end
      S_GAP: begin
        if (bit_end) begin
          if (bit_cnt == BIT_W'(GAP_BITS - 1)) begin
            state_n = S_IDLE;
            bit_n   = '0;
          end else begin
            bit_n = bit_cnt + BIT_W'(1);
          end
        end
      end
      default: state_n = S_QUIET;
    endcase
  end

  // cmd_o is registered from the next shift-register LSB so it changes on the load edge.
  always_ff @(posedge clk33_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= S_QUIET;
      cc      <= '0;
      bit_cnt <= '0;
      sr      <= '0;
      cmd_o   <= 1'b0;
    end else begin
      state   <= state_n;
      cc      <= cc_n;
      bit_cnt <= bit_n;
      sr      <= sr_n;
      cmd_o   <= (state_n == S_SEND) && sr_n[0];
    end
  end

endmodule
`default_nettype wire
